semaforo_multi: RTL and testbench
=================================

Name: semaforo_multi

Overview:
- Parametrised successor of the single-approach traffic light: drives N_DIR approaches at one intersection.
- Internal tick-based phase timers replace the external chrono compare.
- Adds an all-red clearance interval and a minimum-green guarantee.
- Supports three modes: auto cycle, manual request and flashing yellow.
- Sits between the board timebase/inputs and the lamp drivers.

Parameters:
- N_DIR, 2, number of approaches; legal values are 2..8.
- CNT_W, 16, width of the phase timer in ticks.
- GREEN_TIME, 20, green duration in ticks in auto mode.
- MIN_GREEN, 5, minimum green in ticks before a CHANGE request may end green; must be <= GREEN_TIME.
- YELLOW_TIME, 3, yellow duration in ticks.
- ALLRED_TIME, 2, all-red clearance in ticks.
- BLINK_TIME, 1, half-period of the flash-mode yellow in ticks.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  enable; low blanks all lamps.
- TICK  in  1  one-CLK timebase strobe (e.g. 1 ms); timers advance only on TICK.
- MODE  in  2  00 = auto, 01 = manual, 10 = flash, 11 = illegal (handled as flash and raises ERROR).
- CHANGE  in  1  request to end the current green; rising-edge detected.
- GREEN  out  N_DIR  per-approach green lamp.
- YELLOW  out  N_DIR  per-approach yellow lamp.
- RED  out  N_DIR  per-approach red lamp.
- ACTIVE  out  3  index of the approach owning green/yellow (or next to own it during ALLRED).
- ERROR  out  1  registered; high while MODE == 11.

Behaviour:
- All outputs are registered. Every state or lamp change lands on the CLK edge after its cause; there is no combinational path from inputs to lamps.
- Reset (RST_N low, asynchronous): state = ALLRED, timer = 0, ACTIVE = 0, request latch = 0, CHANGE edge register = 0, GREEN = 0, YELLOW = 0, RED = all ones, ERROR = 0.
- States: OFF, ALLRED, GO, CAUTION, FLASH.
- Lamp outputs per state:
  - OFF: all lamps 0.
  - ALLRED: RED all ones.
  - GO: GREEN[ACTIVE] = 1; every other approach RED.
  - CAUTION: YELLOW[ACTIVE] = 1; every other approach RED.
  - FLASH: all YELLOW bits = blink phase; GREEN = RED = 0.
- EN low has priority over everything except reset. Next CLK: state = OFF, timer = 0, request latch = 0.
- EN rising from OFF: next CLK enters ALLRED with ACTIVE = 0.
- Timer: counts TICK pulses within a phase; cleared on every state change. A phase of length T ends on the CLK after the TICK that brings the count to T, so a phase lasts exactly T ticks.
- ALLRED -> GO on expiry, keeping ACTIVE. If MODE is flash or illegal at expiry, go to FLASH instead.
- GO exits to CAUTION on either condition:
  - auto: timer reaches GREEN_TIME, or request latch set and timer >= MIN_GREEN;
  - manual: request latch set and timer >= MIN_GREEN; green holds indefinitely otherwise.
- A CHANGE received before MIN_GREEN stays latched and fires exactly when MIN_GREEN is reached.
- CAUTION -> ALLRED on YELLOW_TIME expiry. ACTIVE increments at that edge and wraps from N_DIR-1 to 0.
- Request latch:
  - set by a CHANGE rising edge only while in GO;
  - edges during CAUTION, ALLRED, FLASH or OFF are ignored, not queued;
  - cleared on leaving GO.
- MODE changes while in GO or CAUTION never cut a phase. The new mode takes effect at the next decision point (GO exit rule or ALLRED expiry).
- FLASH:
  - blink phase starts at 1 on entry and toggles every BLINK_TIME ticks;
  - when MODE returns to 00 or 01, next CLK enters ALLRED with ACTIVE unchanged.
- Simultaneous events:
  - RST_N beats everything, then EN low.
  - A CHANGE edge on the same CLK as green expiry is irrelevant; the phase ends either way and the latch clears.
- Invariants checked by assertions:
  - at most one approach has non-red lamps outside FLASH/OFF;
  - GREEN and YELLOW are never both set on one approach;
  - every GO is preceded by ALLRED.

Decomposition:
- Package semaforo_pkg holds:
  - state enum (OFF, ALLRED, GO, CAUTION, FLASH);
  - MODE constants AUTO = 2'b00, MANUAL = 2'b01, FLASH = 2'b10;
  - lamp code constants red = 3'b001, yellow = 3'b010, green = 3'b100, apagar = 3'b000.
- One natural sub-module, semaforo_phase_timer: CNT_W tick counter with clear, TICK enable and an expired(limit) compare. It is instantiated once for phases and once for blink.

Test Plan:
Common setup unless noted: N_DIR = 2, GREEN_TIME = 5, MIN_GREEN = 2, YELLOW_TIME = 2, ALLRED_TIME = 1, BLINK_TIME = 1, TICK high every CLK, MODE = 00, EN = 1.
- Reset release, auto cycle: RED = 11 for 1 cycle, then GREEN = 01 for 5, YELLOW = 01 for 2, RED = 11 for 1, then GREEN = 10 with ACTIVE = 1; after approach 1's green/yellow/all-red, ACTIVE wraps to 0.
- Early request: CHANGE pulse at green cycle 1 -> latch holds, CAUTION entered after exactly 2 green cycles. A CHANGE pulse during CAUTION -> next green still lasts the full 5.
- Manual mode: MODE = 01 -> green holds 50 cycles unchanged. A CHANGE pulse then gives YELLOW for 2, all-red for 1, then ACTIVE advances.
- Flash and illegal mode: MODE = 11 during GO -> ERROR = 1 next CLK. Green finishes, then yellow, then all-red, then YELLOW toggles 11/00 each cycle with GREEN = RED = 0. MODE = 00 -> ERROR = 0 and one all-red cycle before green.
- Enable: EN = 0 mid-yellow -> all lamps 0 next CLK. EN = 1 -> RED = 11 for 1 cycle, then GREEN = 01.
- Async reset and gapped tick: RST_N low between CLK edges during GO -> RED = 11 immediately, with no CLK needed. With TICK every 4th CLK, GREEN lasts exactly 20 CLKs.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types, mode/lamp encodings and timer compare helper for the
// multi-approach traffic light controller.
package semaforo_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ALLRED,
    ST_GO,
    ST_CAUTION,
    ST_FLASH
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_FLASH  = 2'b10;

  // Per-approach lamp code, packed as {green, yellow, red}.
  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_APAGAR = 3'b000;

  // True when a phase of length `limit` is over: either already reached, or
  // the tick arriving this cycle is the one that brings the count to `limit`.
  function automatic logic tick_reached(input logic [31:0] cnt,
                                        input logic        tick,
                                        input logic [31:0] limit);
    return (cnt >= limit) || (tick && ((cnt + 32'd1) >= limit));
  endfunction

  function automatic logic [2:0] lamp_code(input state_t st,
                                           input logic   is_active,
                                           input logic   blink);
    logic [2:0] code;
    case (st)
      ST_ALLRED:  code = LAMP_RED;
      ST_GO:      code = is_active ? LAMP_GREEN  : LAMP_RED;
      ST_CAUTION: code = is_active ? LAMP_YELLOW : LAMP_RED;
      ST_FLASH:   code = blink     ? LAMP_YELLOW : LAMP_APAGAR;
      default:    code = LAMP_APAGAR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/semaforo_multi_phase_timer.sv
// Saturating tick counter with synchronous clear and a "phase over" compare
// against a run-time limit.
module semaforo_phase_timer
  import semaforo_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_done = tick_reached(32'(r_count), i_tick, 32'(i_limit));

endmodule

// File: rtl/semaforo_multi.sv
// N-approach intersection controller: auto/manual cycling with all-red
// clearance and minimum green, plus flashing-yellow fallback mode.
module semaforo_multi
  import semaforo_pkg::*;
#(
  parameter int N_DIR       = 2,
  parameter int CNT_W       = 16,
  parameter int GREEN_TIME  = 20,
  parameter int MIN_GREEN   = 5,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int BLINK_TIME  = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             TICK,
  input  logic [1:0]       MODE,
  input  logic             CHANGE,
  output logic [N_DIR-1:0] GREEN,
  output logic [N_DIR-1:0] YELLOW,
  output logic [N_DIR-1:0] RED,
  output logic [2:0]       ACTIVE,
  output logic             ERROR
);

  state_t           r_state;
  logic [2:0]       r_active;
  logic             r_req;
  logic             r_change_d;
  logic             r_blink;
  logic             r_error;
  logic [N_DIR-1:0] r_green;
  logic [N_DIR-1:0] r_yellow;
  logic [N_DIR-1:0] r_red;

  state_t           w_next_state;
  logic [2:0]       w_next_active;
  logic             w_next_blink;
  logic             w_change_edge;
  logic             w_phase_clear;
  logic             w_phase_done;
  logic             w_blink_clear;
  logic             w_blink_done;
  logic [CNT_W-1:0] w_phase_limit;
  logic [N_DIR-1:0] w_green;
  logic [N_DIR-1:0] w_yellow;
  logic [N_DIR-1:0] w_red;

  assign w_change_edge = CHANGE & ~r_change_d;

  // A pending request shortens the GO limit to MIN_GREEN; MIN_GREEN <= GREEN_TIME
  // keeps the auto expiry covered by the same compare.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_phase_limit = CNT_W'(GREEN_TIME);
    case (r_state)
      ST_ALLRED:  w_phase_limit = CNT_W'(ALLRED_TIME);
      ST_GO:      w_phase_limit = r_req ? CNT_W'(MIN_GREEN) : CNT_W'(GREEN_TIME);
      ST_CAUTION: w_phase_limit = CNT_W'(YELLOW_TIME);
      default:    w_phase_limit = CNT_W'(GREEN_TIME);
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_active = r_active;
    if (!EN) begin
      w_next_state = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_next_state  = ST_ALLRED;
          w_next_active = 3'd0;
        end
        ST_ALLRED: begin
          if (w_phase_done) w_next_state = MODE[1] ? ST_FLASH : ST_GO;
        end
        ST_GO: begin
          if (w_phase_done && (r_req || (MODE != MODE_MANUAL))) w_next_state = ST_CAUTION;
        end
        ST_CAUTION: begin
          if (w_phase_done) begin
            w_next_state  = ST_ALLRED;
            w_next_active = (r_active == 3'(N_DIR - 1)) ? 3'd0 : r_active + 3'd1;
          end
        end
        ST_FLASH: begin
          if (!MODE[1]) w_next_state = ST_ALLRED;
        end
        default: w_next_state = ST_ALLRED;
      endcase
    end
  end

  assign w_phase_clear = (w_next_state != r_state) || (r_state == ST_OFF);
  assign w_blink_clear = (r_state != ST_FLASH) || w_blink_done;
  assign w_next_blink  = ((w_next_state == ST_FLASH) && (r_state == ST_FLASH))
                         ? (r_blink ^ w_blink_done) : 1'b1;

  always_comb begin
    w_green  = '0;
    w_yellow = '0;
    w_red    = '0;
    for (int i = 0; i < N_DIR; i++) begin
      {w_green[i], w_yellow[i], w_red[i]} =
        lamp_code(w_next_state, (w_next_active == 3'(i)), w_next_blink);
    end
  end

  semaforo_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clear (w_phase_clear),
    .i_tick  (TICK),
    .i_limit (w_phase_limit),
    .o_done  (w_phase_done)
  );

  semaforo_phase_timer #(.CNT_W(CNT_W)) u_blink_timer (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clear (w_blink_clear),
    .i_tick  (TICK),
    .i_limit (CNT_W'(BLINK_TIME)),
    .o_done  (w_blink_done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_ALLRED;
      r_active   <= 3'd0;
      r_req      <= 1'b0;
      r_change_d <= 1'b0;
      r_blink    <= 1'b1;
      r_error    <= 1'b0;
      r_green    <= '0;
      r_yellow   <= '0;
      r_red      <= '1;
    end else begin
      r_state    <= w_next_state;
      r_active   <= w_next_active;
      r_change_d <= CHANGE;
      r_blink    <= w_next_blink;
      r_error    <= (MODE == 2'b11);
      r_green    <= w_green;
      r_yellow   <= w_yellow;
      r_red      <= w_red;
      // Requests only count while green is showing and die when it ends.
      r_req      <= ((r_state == ST_GO) && (w_next_state == ST_GO)) ? (r_req | w_change_edge) : 1'b0;
    end
  end

  assign GREEN  = r_green;
  assign YELLOW = r_yellow;
  assign RED    = r_red;
  assign ACTIVE = r_active;
  assign ERROR  = r_error;

  a_single_owner: assert property (@(posedge CLK) disable iff (!RST_N)
    ((r_state != ST_FLASH) && (r_state != ST_OFF)) |-> $onehot0(r_green | r_yellow));

  a_no_green_yellow: assert property (@(posedge CLK) disable iff (!RST_N)
    (r_green & r_yellow) == '0);

  a_go_after_allred: assert property (@(posedge CLK) disable iff (!RST_N)
    ((r_state == ST_GO) && ($past(r_state) != ST_GO)) |-> ($past(r_state) == ST_ALLRED));

endmodule

// File: tb/tb_semaforo_multi.sv
// Table-driven, scoreboard-checked bench for semaforo_multi with two approaches.
module tb_semaforo_multi;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       TICK;
  logic [1:0] MODE;
  logic       CHANGE;
  logic [1:0] GREEN;
  logic [1:0] YELLOW;
  logic [1:0] RED;
  logic [2:0] ACTIVE;
  logic       ERROR;

  semaforo_multi #(
    .N_DIR       (2),
    .CNT_W       (16),
    .GREEN_TIME  (5),
    .MIN_GREEN   (2),
    .YELLOW_TIME (2),
    .ALLRED_TIME (1),
    .BLINK_TIME  (1)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EN     (EN),
    .TICK   (TICK),
    .MODE   (MODE),
    .CHANGE (CHANGE),
    .GREEN  (GREEN),
    .YELLOW (YELLOW),
    .RED    (RED),
    .ACTIVE (ACTIVE),
    .ERROR  (ERROR)
  );

  typedef enum logic [2:0] {L_OFF, L_AR, L_GO, L_CA, L_FY, L_FN} lamp_e;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       chg;
    lamp_e      kind;
    logic [2:0] act;
    logic       err;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [1:0] m, input logic c,
                     input lamp_e k, input logic [2:0] a, input logic e, input int n);
    vec_t v;
    v.en = en; v.mode = m; v.chg = c; v.kind = k; v.act = a; v.err = e;
    for (int j = 0; j < n; j++) vecs.push_back(v);
  endtask

  // Expected {GREEN, YELLOW, RED, ACTIVE, ERROR} for two approaches.
  function automatic logic [9:0] exp_bits(input lamp_e k, input logic [2:0] a, input logic e);
    logic [1:0] oh;
    logic [1:0] g;
    logic [1:0] y;
    logic [1:0] r;
    oh = 2'b01 << a;
    g = 2'b00; y = 2'b00; r = 2'b00;
    case (k)
      L_AR: r = 2'b11;
      L_GO: begin g = oh; r = ~oh; end
      L_CA: begin y = oh; r = ~oh; end
      L_FY: y = 2'b11;
      default: ;
    endcase
    return {g, y, r, a, e};
  endfunction

  initial begin
    int green_cnt;
    bit seen_green;

    RST_N = 1'b0; EN = 1'b1; MODE = 2'b00; CHANGE = 1'b0; TICK = 1'b1;

    // Auto cycle from reset: approach 0, approach 1, wrap back to 0.
    add(1, 0, 0, L_GO, 0, 0, 5);
    add(1, 0, 0, L_CA, 0, 0, 2);
    add(1, 0, 0, L_AR, 1, 0, 1);
    add(1, 0, 0, L_GO, 1, 0, 5);
    add(1, 0, 0, L_CA, 1, 0, 2);
    add(1, 0, 0, L_AR, 0, 0, 1);
    add(1, 0, 0, L_GO, 0, 0, 1);
    // Early request latched before MIN_GREEN; request during yellow ignored.
    add(1, 0, 1, L_GO, 0, 0, 1);
    add(1, 0, 0, L_CA, 0, 0, 1);
    add(1, 0, 1, L_CA, 0, 0, 1);
    add(1, 0, 0, L_AR, 1, 0, 1);
    add(1, 0, 0, L_GO, 1, 0, 5);
    add(1, 0, 0, L_CA, 1, 0, 2);
    add(1, 0, 0, L_AR, 0, 0, 1);
    add(1, 0, 0, L_GO, 0, 0, 1);
    // Manual: green holds, a request ends it.
    add(1, 1, 0, L_GO, 0, 0, 50);
    add(1, 1, 1, L_GO, 0, 0, 1);
    add(1, 1, 0, L_CA, 0, 0, 2);
    add(1, 1, 0, L_AR, 1, 0, 1);
    add(1, 1, 0, L_GO, 1, 0, 1);
    // Illegal mode: phase completes, then flashing yellow, then recovery.
    add(1, 3, 0, L_GO, 1, 1, 4);
    add(1, 3, 0, L_CA, 1, 1, 2);
    add(1, 3, 0, L_AR, 0, 1, 1);
    add(1, 3, 0, L_FY, 0, 1, 1);
    add(1, 3, 0, L_FN, 0, 1, 1);
    add(1, 3, 0, L_FY, 0, 1, 1);
    add(1, 3, 0, L_FN, 0, 1, 1);
    add(1, 0, 0, L_AR, 0, 0, 1);
    add(1, 0, 0, L_GO, 0, 0, 1);
    // Enable drop mid-yellow and restart.
    add(1, 0, 0, L_GO, 0, 0, 4);
    add(1, 0, 0, L_CA, 0, 0, 1);
    add(0, 0, 0, L_OFF, 0, 0, 2);
    add(1, 0, 0, L_AR, 0, 0, 1);
    add(1, 0, 0, L_GO, 0, 0, 1);

    repeat (3) @(negedge CLK);
    check("rst_green",  GREEN,  2'b00);
    check("rst_yellow", YELLOW, 2'b00);
    check("rst_red",    RED,    2'b11);
    check("rst_active", ACTIVE, 3'd0);
    check("rst_error",  ERROR,  1'b0);

    RST_N = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      EN = vecs[i].en; MODE = vecs[i].mode; CHANGE = vecs[i].chg; TICK = 1'b1;
      sb_q.push_back(exp_bits(vecs[i].kind, vecs[i].act, vecs[i].err));
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d", i + 1), {22'd0, GREEN, YELLOW, RED, ACTIVE, ERROR},
            {22'd0, sb_q.pop_front()});
      @(negedge CLK);
    end

    // Asynchronous reset between clock edges while green is showing.
    check("pre_rst_green", GREEN, 2'b01);
    RST_N = 1'b0;
    #1;
    check("async_rst_red",    RED,    2'b11);
    check("async_rst_green",  GREEN,  2'b00);
    check("async_rst_active", ACTIVE, 3'd0);
    repeat (2) @(negedge CLK);

    // Gapped timebase: one tick every 4 clocks, green must span 20 clocks.
    RST_N = 1'b1;
    green_cnt  = 0;
    seen_green = 1'b0;
    for (int k = 0; k < 100; k++) begin
      TICK = ((k % 4) == 0);
      @(posedge CLK);
      #1;
      if (GREEN != 2'b00) begin
        green_cnt++;
        seen_green = 1'b1;
      end else if (seen_green) begin
        break;
      end
      @(negedge CLK);
    end
    check("gapped_green_len", green_cnt, 20);
    check("gapped_then_yellow", YELLOW, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
